// File: rtl/dpwm_pkg.sv
// dpwm_pkg: shared definitions for the digital PWM duty generator.
//   - FSM state encoding for the duty-to-compare conversion
//   - datapath width constants
//   - default full-scale duty value
//   - clamp_duty(): saturates a signed duty word into the unsigned compare-path width
package dpwm_pkg;

  localparam int unsigned CNT_W          = 16;
  localparam int unsigned DUTY_W         = 27;
  localparam int unsigned DC_W           = 14;
  localparam int unsigned PROD_W         = 30;
  localparam int unsigned QUOT_W         = PROD_W - DC_W;
  localparam int unsigned D_FULL_DEFAULT = 10000;

  typedef enum logic [2:0] {
    StIdle,
    StCapture,
    StMult,
    StDiv,
    StDone
  } dpwm_state_e;

  // lo/hi are non-negative and below 2**DC_W, so the narrowed result is exact.
  function automatic logic [DC_W-1:0] clamp_duty(input logic signed [DUTY_W-1:0] d,
                                                 input logic signed [DUTY_W-1:0] lo,
                                                 input logic signed [DUTY_W-1:0] hi);
    if (d < lo) begin
      return lo[DC_W-1:0];
    end else if (d > hi) begin
      return hi[DC_W-1:0];
    end else begin
      return d[DC_W-1:0];
    end
  endfunction

endpackage

// File: rtl/dpwm_seq_div.sv
// dpwm_seq_div: sequential restoring divider, PROD_W-bit dividend by DC_W-bit divisor.
// Produces one quotient bit per cycle, MSB first, over QUOT_W (16) cycles.
// The caller guarantees dividend / divisor < 2**QUOT_W, i.e. the top DC_W dividend bits
// are already below the divisor, so they seed the partial remainder directly.
// Ports:
//   clk_i       clock
//   rst_i       synchronous active-high reset, aborts a running division
//   start_i     one-cycle pulse; dividend_i is consumed and the first bit computed this cycle
//   dividend_i  dividend, must be stable while start_i is high
//   divisor_i   divisor, must be stable for the whole division
//   done_o      high in the cycle that computes the final bit; quotient_o valid next cycle
//   quotient_o  truncated quotient
module dpwm_seq_div
  import dpwm_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [PROD_W-1:0] dividend_i,
  input  logic [DC_W-1:0]   divisor_i,
  output logic              done_o,
  output logic [QUOT_W-1:0] quotient_o
);

  localparam logic [3:0] LastIter = 4'(QUOT_W - 1);

  logic [DC_W-1:0]   rem_q, rem_d;
  logic [QUOT_W-1:0] bits_q, bits_d;
  logic [QUOT_W-1:0] quot_q, quot_d;
  logic [3:0]        iter_q, iter_d;
  logic              run_q, run_d;

  logic [DC_W-1:0] step_rem_in;
  logic            step_bit;
  logic [DC_W:0]   trial;
  logic            qbit;
  logic [DC_W-1:0] step_rem_out;

  // One restoring step; on start it works straight off the dividend input.
  always_comb begin
    step_rem_in  = start_i ? dividend_i[PROD_W-1 -: DC_W] : rem_q;
    step_bit     = start_i ? dividend_i[QUOT_W-1] : bits_q[QUOT_W-1];
    trial        = {step_rem_in, step_bit};
    qbit         = (trial >= {1'b0, divisor_i});
    // When qbit is set the difference is below the divisor, so DC_W bits suffice.
    step_rem_out = qbit ? (trial[DC_W-1:0] - divisor_i) : trial[DC_W-1:0];
  end

  always_comb begin
    rem_d  = rem_q;
    bits_d = bits_q;
    quot_d = quot_q;
    iter_d = iter_q;
    run_d  = run_q;
    if (start_i) begin
      rem_d  = step_rem_out;
      bits_d = {dividend_i[QUOT_W-2:0], 1'b0};
      quot_d = {{(QUOT_W-1){1'b0}}, qbit};
      iter_d = 4'd1;
      run_d  = 1'b1;
    end else if (run_q) begin
      rem_d  = step_rem_out;
      bits_d = {bits_q[QUOT_W-2:0], 1'b0};
      quot_d = {quot_q[QUOT_W-2:0], qbit};
      iter_d = iter_q + 4'd1;
      if (iter_q == LastIter) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_q  <= '0;
      bits_q <= '0;
      quot_q <= '0;
      iter_q <= '0;
      run_q  <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      bits_q <= bits_d;
      quot_q <= quot_d;
      iter_q <= iter_d;
      run_q  <= run_d;
    end
  end

  assign done_o     = run_q && (iter_q == LastIter);
  assign quotient_o = quot_q;

endmodule

// File: rtl/dpwm_duty_gen.sv
// dpwm_duty_gen: digital PWM stage fed by the compensator's signed duty word.
// Each period the duty word is captured, clamped to [D_MIN, D_MAX], scaled to a compare
// value (D * PERIOD / D_FULL, truncated) and loaded into cmp_active at the period boundary.
// Optional build macro DPWM_DEADTIME_EN: complementary pwm_lo output with DEADTIME guard
// cycles; without it pwm_lo is tied low and DEADTIME only takes part in the parameter check.
// Ports:
//   clk_50        50 MHz system clock
//   iRST          synchronous active-high reset
//   d_in          signed duty word, 10000 = 100 %
//   pwm_hi        high-side gate drive (registered)
//   pwm_lo        low-side gate drive (registered, dead-time build only)
//   adc_trig      one-cycle pulse in the cycle after cnt == ADC_TRIG_CNT
//   period_start  one-cycle pulse in the cycle after cnt == 0
//   cmp_active    compare value in force this period
//   clamped       last captured d_in was outside [D_MIN, D_MAX]
//   busy          conversion in progress
module dpwm_duty_gen
  import dpwm_pkg::*;
#(
  parameter int unsigned PERIOD       = 400,
  parameter int unsigned D_FULL       = D_FULL_DEFAULT,
  parameter int unsigned D_MIN        = 0,
  parameter int unsigned D_MAX        = 9000,
  parameter int unsigned ADC_TRIG_CNT = 200,
  parameter int unsigned DEADTIME     = 10
) (
  input  logic                     clk_50,
  input  logic                     iRST,
  input  logic signed [DUTY_W-1:0] d_in,
  output logic                     pwm_hi,
  output logic                     pwm_lo,
  output logic                     adc_trig,
  output logic                     period_start,
  output logic [CNT_W-1:0]         cmp_active,
  output logic                     clamped,
  output logic                     busy
);

  localparam bit CfgOk = (PERIOD >= 32) && (PERIOD <= 65535) && (D_MIN <= D_MAX) &&
                         (D_MAX <= D_FULL) && (D_FULL < (1 << DC_W)) &&
                         (ADC_TRIG_CNT < PERIOD) && (DEADTIME < PERIOD);

  if (!CfgOk) begin : g_cfg_err
    $error("dpwm_duty_gen: inconsistent parameter set");
  end

  localparam logic [CNT_W-1:0]         PeriodLast = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0]         AdcCnt     = CNT_W'(ADC_TRIG_CNT);
  localparam logic signed [DUTY_W-1:0] DMinS      = DUTY_W'(D_MIN);
  localparam logic signed [DUTY_W-1:0] DMaxS      = DUTY_W'(D_MAX);
  localparam logic [DC_W-1:0]          DivisorC   = DC_W'(D_FULL);
  localparam logic [PROD_W-1:0]        PeriodP    = PROD_W'(PERIOD);
`ifdef DPWM_DEADTIME_EN
  localparam logic [CNT_W-1:0]         DeadC      = CNT_W'(DEADTIME);
`endif

  // Period counter and registered timing outputs
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cmp_q;
  logic             ps_q, adc_q, hi_q, lo_q;
  logic             hi_d, lo_d;

  // Conversion FSM and datapath
  dpwm_state_e       state_q;
  logic [DC_W-1:0]   dc_q;
  logic [PROD_W-1:0] prod_q;
  logic [CNT_W-1:0]  shadow_q;
  logic              clamped_q, busy_q, div_start_q;
  logic              div_done;
  logic [QUOT_W-1:0] div_quot;

  always_comb begin
`ifdef DPWM_DEADTIME_EN
    // cnt never exceeds PERIOD-1, so pwm_lo needs only the lower bound.
    hi_d = (cnt_q >= DeadC) && (cnt_q < cmp_q);
    lo_d = ({1'b0, cnt_q} >= ({1'b0, cmp_q} + {1'b0, DeadC}));
`else
    hi_d = (cnt_q < cmp_q);
    lo_d = 1'b0;
`endif
  end

  always_ff @(posedge clk_50) begin
    if (iRST) begin
      cnt_q <= '0;
      cmp_q <= '0;
      ps_q  <= 1'b0;
      adc_q <= 1'b0;
      hi_q  <= 1'b0;
      lo_q  <= 1'b0;
    end else begin
      cnt_q <= (cnt_q == PeriodLast) ? '0 : cnt_q + CNT_W'(1);
      ps_q  <= (cnt_q == '0);
      adc_q <= (cnt_q == AdcCnt);
      // Loading on the last count keeps the compare value constant across a whole period.
      if (cnt_q == PeriodLast) begin
        cmp_q <= shadow_q;
      end
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // CAPTURE (1) + MULT (1) + DIV (16) + DONE (1) = 19 cycles, well inside a period.
  always_ff @(posedge clk_50) begin
    if (iRST) begin
      state_q     <= StIdle;
      dc_q        <= '0;
      prod_q      <= '0;
      shadow_q    <= '0;
      clamped_q   <= 1'b0;
      busy_q      <= 1'b0;
      div_start_q <= 1'b0;
    end else begin
      div_start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cnt_q == '0) begin
            state_q <= StCapture;
            busy_q  <= 1'b1;
          end
        end
        StCapture: begin
          dc_q      <= clamp_duty(d_in, DMinS, DMaxS);
          clamped_q <= (d_in < DMinS) || (d_in > DMaxS);
          state_q   <= StMult;
        end
        StMult: begin
          prod_q      <= PROD_W'(dc_q) * PeriodP;
          div_start_q <= 1'b1;
          state_q     <= StDiv;
        end
        StDiv: begin
          if (div_done) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          shadow_q <= div_quot;
          busy_q   <= 1'b0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  dpwm_seq_div u_div (
    .clk_i      (clk_50),
    .rst_i      (iRST),
    .start_i    (div_start_q),
    .dividend_i (prod_q),
    .divisor_i  (DivisorC),
    .done_o     (div_done),
    .quotient_o (div_quot)
  );

  assign pwm_hi       = hi_q;
  assign pwm_lo       = lo_q;
  assign adc_trig     = adc_q;
  assign period_start = ps_q;
  assign cmp_active   = cmp_q;
  assign clamped      = clamped_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_dpwm_duty_gen.sv
// Scoreboard bench for dpwm_duty_gen. The stimulus process pushes one expectation per
// PWM period; the monitor measures each period window (period_start to period_start)
// and compares it against the front of the queue.
module tb_dpwm_duty_gen;
  import dpwm_pkg::*;

  localparam int PERIOD = 400;
  localparam int ADC    = 200;
  localparam int DT     = 10;
  localparam int NV     = 14;

  logic                     clk_50 = 1'b0;
  logic                     iRST;
  logic signed [DUTY_W-1:0] d_in;
  logic                     pwm_hi, pwm_lo, adc_trig, period_start, clamped, busy;
  logic [CNT_W-1:0]         cmp_active;

  always #10 clk_50 = ~clk_50;

  dpwm_duty_gen #(
    .PERIOD       (PERIOD),
    .D_FULL       (10000),
    .D_MIN        (0),
    .D_MAX        (9000),
    .ADC_TRIG_CNT (ADC),
    .DEADTIME     (DT)
  ) dut (
    .clk_50       (clk_50),
    .iRST         (iRST),
    .d_in         (d_in),
    .pwm_hi       (pwm_hi),
    .pwm_lo       (pwm_lo),
    .adc_trig     (adc_trig),
    .period_start (period_start),
    .cmp_active   (cmp_active),
    .clamped      (clamped),
    .busy         (busy)
  );

  // Entries 0..10: first run after reset; 11..13: run after the mid-DIV reset.
  int vec_d   [NV] = '{5000, 12000, -30, 3333, 7000, 9000, 0, 10000, 1, 200, 5000,
                       3333, 7000, 7000};
  int vec_cmp [NV] = '{200, 360, 0, 133, 280, 360, 0, 360, 0, 8, 200,
                       133, 280, 280};
  int vec_clp [NV] = '{0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0,
                       0, 0, 0};

  typedef struct {
    int tag;
    int cmp;
    int hi;
    int lo;
    int first_hi;
    int clp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int tag, input int cmp, input int clp);
    exp_t e;
    e.tag = tag;
    e.cmp = cmp;
    e.clp = clp;
`ifdef DPWM_DEADTIME_EN
    e.hi       = (cmp > DT) ? cmp - DT : 0;
    e.lo       = (cmp + DT < PERIOD) ? PERIOD - cmp - DT : 0;
    e.first_hi = DT;
`else
    e.hi       = cmp;
    e.lo       = 0;
    e.first_hi = 0;
`endif
    sb.push_back(e);
  endtask

  // Monitor: window sample i reflects counter value i (outputs lag cnt by one cycle).
  int mon_idx, win_len, hi_cnt, lo_cnt, ovl_cnt, adc_cnt, adc_off, first_hi, cmp_smp, clp_smp;
  bit win_on;

  initial begin
    exp_t e;
    win_on  = 1'b0;
    mon_idx = 0;
    forever begin
      @(negedge clk_50);
      if (iRST) begin
        win_on  = 1'b0;
        mon_idx = 0;
      end else begin
        if (period_start) begin
          if (win_on) begin
            if (sb.size() > 0 && sb[0].tag == mon_idx) begin
              e = sb.pop_front();
              check($sformatf("p%0d cmp_active", mon_idx), cmp_smp, e.cmp);
              check($sformatf("p%0d pwm_hi count", mon_idx), hi_cnt, e.hi);
              check($sformatf("p%0d pwm_lo count", mon_idx), lo_cnt, e.lo);
              check($sformatf("p%0d clamped", mon_idx), clp_smp, e.clp);
              check($sformatf("p%0d adc_trig pulses", mon_idx), adc_cnt, 1);
              check($sformatf("p%0d adc_trig offset", mon_idx), adc_off, ADC);
              check($sformatf("p%0d period length", mon_idx), win_len, PERIOD);
              check($sformatf("p%0d hi/lo overlap", mon_idx), ovl_cnt, 0);
              if (e.hi > 0) begin
                check($sformatf("p%0d first pwm_hi", mon_idx), first_hi, e.first_hi);
              end
            end
            mon_idx++;
          end
          win_on   = 1'b1;
          win_len  = 0;
          hi_cnt   = 0;
          lo_cnt   = 0;
          ovl_cnt  = 0;
          adc_cnt  = 0;
          adc_off  = -1;
          first_hi = -1;
          cmp_smp  = -1;
        end
        if (win_on) begin
          if (pwm_hi) begin
            hi_cnt++;
            if (first_hi < 0) first_hi = win_len;
          end
          if (pwm_lo) lo_cnt++;
          if (pwm_hi && pwm_lo) ovl_cnt++;
          if (adc_trig) begin
            adc_cnt++;
            adc_off = win_len;
          end
          if (win_len == 100) cmp_smp = int'(cmp_active);
          clp_smp = int'(clamped);
          win_len++;
        end
      end
    end
  end

  task automatic wait_ps(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      @(negedge clk_50);
      if (period_start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL period_start timeout: got none, expected a pulse within %0d cycles",
               2 * PERIOD);
    end
  endtask

  // Runs table entries lo..hi; d_in must already hold vec_d[lo]. Starts right after reset.
  task automatic run_seq(input int lo, input int hi);
    bit ok;
    int prev = 0;
    for (int p = lo; p <= hi; p++) begin
      wait_ps(ok);
      if (!ok) break;
      push(p - lo, prev, vec_clp[p]);
      repeat (150) @(negedge clk_50);
      if (p < hi) d_in = DUTY_W'(vec_d[p + 1]);
      prev = vec_cmp[p];
    end
    wait_ps(ok);
  endtask

  initial begin
    bit ok;
    iRST = 1'b1;
    d_in = DUTY_W'(vec_d[0]);
    repeat (4) @(negedge clk_50);
    check("reset pwm_hi", int'(pwm_hi), 0);
    check("reset pwm_lo", int'(pwm_lo), 0);
    check("reset adc_trig", int'(adc_trig), 0);
    check("reset period_start", int'(period_start), 0);
    check("reset cmp_active", int'(cmp_active), 0);
    check("reset clamped", int'(clamped), 0);
    check("reset busy", int'(busy), 0);
    iRST = 1'b0;

    run_seq(0, 10);

    // The final wait in run_seq stopped in the CAPTURE cycle; six cycles later DIV runs.
    d_in = DUTY_W'(vec_d[11]);
    repeat (6) @(negedge clk_50);
    check("busy during DIV", int'(busy), 1);
    iRST = 1'b1;
    repeat (2) @(negedge clk_50);
    check("abort busy", int'(busy), 0);
    check("abort cmp_active", int'(cmp_active), 0);
    check("abort clamped", int'(clamped), 0);
    check("abort pwm_hi", int'(pwm_hi), 0);
    iRST = 1'b0;

    run_seq(11, 13);

    repeat (2) @(negedge clk_50);
    check("scoreboard drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
